// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - multiplexed 7-segment bus reader
// Debounces each digit-select strobe window, decodes its glyph and publishes full BCD frames.
module seg7_scan_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   dig_n,
  output logic [4*NDIG-1:0] bcd,
  output logic              frame_valid,
  output logic [NDIG-1:0]   digit_err,
  output logic              sel_err
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  localparam logic [3:0] CAP_CNT = 4'(STABLE - 2);

  state_t              state, state_next;
  logic [6:0]          seg_r, seg_p;
  logic [NDIG-1:0]     dig_r, dig_p;
  logic [3:0]          cnt, cnt_next;
  logic [NDIG-1:0]     mask, mask_next;
  logic [NDIG-1:0]     stage_err, stage_err_next;
  logic [4*NDIG-1:0]   stage_bcd, stage_bcd_next;
  logic [NDIG-1:0]     low;
  logic                one_hot, multi_low, changed, capture, frame_done;
  logic [3:0]          code;
  logic                code_err;

  always_comb begin
    low       = ~dig_r;
    one_hot   = (low != '0) && ((low & (low - 1'b1)) == '0);
    multi_low = (low != '0) && !one_hot;
    changed   = (seg_r != seg_p) || (dig_r != dig_p);
  end

  always_comb begin
    code     = 4'hE;
    code_err = 1'b0;
    case (seg_r)
      7'h40: code = 4'h0;
      7'h79: code = 4'h1;
      7'h24: code = 4'h2;
      7'h30: code = 4'h3;
      7'h19: code = 4'h4;
      7'h12: code = 4'h5;
      7'h02: code = 4'h6;
      7'h78: code = 4'h7;
      7'h00: code = 4'h8;
      7'h10: code = 4'h9;
      7'h7F: code = 4'hF;
      default: code_err = 1'b1;
    endcase
  end

  // Any change of the sampled bus restarts settling; a held window never re-captures.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    if (changed) begin
      cnt_next   = 4'd0;
      state_next = one_hot ? S_SETTLE : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (one_hot) state_next = S_SETTLE;
        end
        S_SETTLE: begin
          if (!one_hot) begin
            state_next = S_IDLE;
          end else begin
            cnt_next = cnt + 4'd1;
            if (cnt == CAP_CNT) begin
              capture    = 1'b1;
              state_next = S_HELD;
            end
          end
        end
        S_HELD: state_next = S_HELD;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mask_next      = mask;
    stage_bcd_next = stage_bcd;
    stage_err_next = stage_err;
    for (int i = 0; i < NDIG; i++) begin
      if (capture && low[i]) begin
        mask_next[i]           = 1'b1;
        stage_bcd_next[4*i +: 4] = code;
        stage_err_next[i]      = code_err;
      end
    end
    frame_done = capture && (mask_next == '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r       <= '1;
      seg_p       <= '1;
      dig_r       <= '1;
      dig_p       <= '1;
      state       <= S_IDLE;
      cnt         <= 4'd0;
      mask        <= '0;
      stage_bcd   <= '0;
      stage_err   <= '0;
      bcd         <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      seg_r       <= seg_n;
      dig_r       <= dig_n;
      seg_p       <= seg_r;
      dig_p       <= dig_r;
      state       <= state_next;
      cnt         <= cnt_next;
      stage_bcd   <= stage_bcd_next;
      stage_err   <= stage_err_next;
      sel_err     <= sel_err | multi_low;
      frame_valid <= frame_done;
      if (frame_done) begin
        bcd       <= stage_bcd_next;
        digit_err <= stage_err_next;
        mask      <= '0;
      end else begin
        mask      <= mask_next;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - bench for seg7_scan_reader
// Directed scan scenarios plus random strobe windows checked every cycle against a run-length model.
module tb_seg7_scan_reader;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   dig_n;
  logic [4*NDIG-1:0] bcd;
  logic              frame_valid;
  logic [NDIG-1:0]   digit_err;
  logic              sel_err;

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst), .seg_n(seg_n), .dig_n(dig_n),
    .bcd(bcd), .frame_valid(frame_valid), .digit_err(digit_err), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fv_seen = 0;

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // reference model state
  logic [6:0]        m_prev_seg;
  logic [NDIG-1:0]   m_prev_dig;
  int                m_run;
  logic              m_pend, m_pend_sel;
  logic [6:0]        m_pend_seg;
  logic [NDIG-1:0]   m_pend_dig;
  logic [3:0]        m_code [NDIG];
  logic [NDIG-1:0]   m_err, m_mask;
  logic [4*NDIG-1:0] exp_bcd;
  logic [NDIG-1:0]   exp_err;
  logic              exp_fv, exp_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (s == glyph[k]) return {1'b0, 4'(k)};
    if (s == 7'h7F) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  task automatic do_capture(input logic [6:0] s, input logic [NDIG-1:0] d);
    int idx = 0;
    logic [4:0] dc;
    for (int i = 0; i < NDIG; i++) if (!d[i]) idx = i;
    dc = decode(s);
    m_code[idx] = dc[3:0];
    m_err[idx]  = dc[4];
    m_mask[idx] = 1'b1;
    if (m_mask == '1) begin
      for (int i = 0; i < NDIG; i++) exp_bcd[4*i +: 4] = m_code[i];
      exp_err = m_err;
      exp_fv  = 1'b1;
      m_mask  = '0;
    end
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [NDIG-1:0] d, input logic r);
    if (r) begin
      m_mask = '0; m_err = '0; exp_bcd = '0; exp_err = '0;
      exp_fv = 1'b0; exp_sel = 1'b0; m_pend = 1'b0; m_pend_sel = 1'b0;
      m_prev_seg = 7'h7F; m_prev_dig = '1; m_run = 0;
      for (int i = 0; i < NDIG; i++) m_code[i] = 4'h0;
    end else begin
      exp_fv = 1'b0;
      if (m_pend_sel) exp_sel = 1'b1;
      if (m_pend) do_capture(m_pend_seg, m_pend_dig);
      m_pend     = 1'b0;
      m_pend_sel = ($countones(~d) > 1);
      if (s == m_prev_seg && d == m_prev_dig) m_run++;
      else m_run = 1;
      m_prev_seg = s;
      m_prev_dig = d;
      if (m_run == STABLE && $countones(~d) == 1) begin
        m_pend = 1'b1; m_pend_seg = s; m_pend_dig = d;
      end
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [NDIG-1:0] d, input logic r);
    rst = r; seg_n = s; dig_n = d;
    @(posedge clk);
    model_edge(s, d, r);
    @(negedge clk);
    if (frame_valid === 1'b1) fv_seen++;
    chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
    chk("bcd", 32'(bcd), 32'(exp_bcd));
    chk("digit_err", 32'(digit_err), 32'(exp_err));
    chk("sel_err", 32'(sel_err), 32'(exp_sel));
  endtask

  task automatic window(input int dig, input logic [6:0] s, input int len);
    logic [NDIG-1:0] d;
    d = '1;
    d[dig] = 1'b0;
    repeat (len) step(s, d, 1'b0);
  endtask

  task automatic idle(input int len);
    repeat (len) step(7'h7F, '1, 1'b0);
  endtask

  task automatic scan(input logic [6:0] s0, s1, s2, s3, input int len);
    window(0, s0, len); window(1, s1, len); window(2, s2, len); window(3, s3, len);
  endtask

  initial begin
    int f0;
    logic [6:0] s;
    logic [NDIG-1:0] d;
    int r;

    step(7'h7F, '1, 1'b1);
    step(7'h7F, '1, 1'b1);
    chk("reset_bcd", 32'(bcd), 32'h0);
    chk("reset_sel", 32'(sel_err), 32'h0);

    f0 = fv_seen;
    scan(7'h79, 7'h24, 7'h30, 7'h19, 4);
    idle(3);
    chk("scan1_bcd", 32'(bcd), 32'h4321);
    chk("scan1_err", 32'(digit_err), 32'h0);
    chk("scan1_frames", 32'(fv_seen - f0), 32'd1);

    f0 = fv_seen;
    window(0, 7'h79, 4); window(1, 7'h24, 4); window(2, 7'h30, 2); window(3, 7'h19, 4);
    idle(3);
    chk("short_frames", 32'(fv_seen - f0), 32'd0);
    window(2, 7'h30, 4);
    idle(3);
    chk("short_retry_frames", 32'(fv_seen - f0), 32'd1);
    chk("short_retry_bcd", 32'(bcd), 32'h4321);

    scan(7'h40, 7'h55, 7'h40, 7'h7F, 4);
    idle(3);
    chk("illegal_bcd", 32'(bcd), 32'hF0E0);
    chk("illegal_err", 32'(digit_err), 32'b0010);

    f0 = fv_seen;
    window(0, 7'h10, 4);
    repeat (5) step(7'h40, 4'b1100, 1'b0);
    idle(2);
    chk("multi_sel", 32'(sel_err), 32'h1);
    chk("multi_frames", 32'(fv_seen - f0), 32'd0);
    scan(7'h10, 7'h00, 7'h78, 7'h02, 4);
    idle(3);
    chk("multi_bcd", 32'(bcd), 32'h6789);
    chk("multi_sel_sticky", 32'(sel_err), 32'h1);

    f0 = fv_seen;
    window(0, 7'h40, 4); window(1, 7'h40, 4); window(2, 7'h40, 4);
    step(7'h40, 4'b1011, 1'b1);
    idle(2);
    chk("rst_mid_frames", 32'(fv_seen - f0), 32'd0);
    chk("rst_mid_sel", 32'(sel_err), 32'h0);
    scan(7'h40, 7'h40, 7'h40, 7'h40, 4);
    idle(3);
    chk("rst_after_bcd", 32'(bcd), 32'h0000);
    chk("rst_after_frames", 32'(fv_seen - f0), 32'd1);

    f0 = fv_seen;
    window(0, 7'h19, 20);
    idle(2);
    chk("held_frames", 32'(fv_seen - f0), 32'd0);
    window(0, 7'h12, 4); window(1, 7'h40, 4); window(2, 7'h40, 4); window(3, 7'h40, 4);
    idle(3);
    chk("held_digit0", 32'(bcd[3:0]), 32'h5);
    chk("held_frames2", 32'(fv_seen - f0), 32'd1);

    for (int w = 0; w < 600; w++) begin
      r = $urandom_range(0, 99);
      if (r < 80) s = glyph[$urandom_range(0, 9)];
      else if (r < 90) s = 7'h7F;
      else s = 7'($urandom);
      r = $urandom_range(0, 99);
      d = '1;
      if (r < 90) d[$urandom_range(0, NDIG-1)] = 1'b0;
      else if (r >= 95) d = NDIG'($urandom);
      if ($urandom_range(0, 99) == 0) step(s, d, 1'b1);
      else repeat ($urandom_range(1, 6)) step(s, d, 1'b0);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive side of the multiplexed 7-segment display bus: samples active-low segment lines and active-low digit-select strobes, then reconstructs one BCD code per digit.
- Checks each segment pattern against the team's fixed 0–9 glyph table and flags illegal glyphs.
- Publishes a complete frame of NDIG digits with a one-cycle valid pulse.
- Used for display loopback self-test and for reading scanned displays back into the datapath.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE, 3, consecutive identical samples required before a digit is captured (2..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- seg_n  in  7  segment lines, active-low; bit0=a, bit1=b, … bit6=g.
- dig_n  in  NDIG  digit selects, active-low, one-hot when valid; bit0 = digit 0.
- bcd  out  4*NDIG  published codes; bits [4i+3:4i] = digit i.
- frame_valid  out  1  one-cycle pulse when bcd/digit_err update.
- digit_err  out  NDIG  per-digit illegal-glyph flags for the published frame.
- sel_err  out  1  sticky: more than one dig_n bit low was seen; cleared only by rst.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: bcd=0, frame_valid=0, digit_err=0, sel_err=0, input registers=all ones, stability counter=0, captured mask=0, FSM=S_IDLE. Any partial frame is discarded.
- Input stage: seg_n and dig_n are registered once (seg_r, dig_r). All decisions use the registered values.
- Glyph table (seg_n hex, g..a, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 7F (all off) = blank, code 4'hF, not an error.
  - Any other pattern = code 4'hE and error bit set.
- "Identical sample": (seg_r, dig_r) equal to the previous cycle's value. Any change resets the stability counter to 0.
- FSM:
  - S_IDLE: dig_r has no bit low, or the counter is still settling. Move to S_SETTLE when dig_r is one-hot low.
  - S_SETTLE: counter increments on each identical sample.
    - When the counter reaches STABLE-1, capture on that edge: write the decoded code into staging slot i and set mask bit i and err bit i. Then go to S_HELD.
    - Any change in seg_r/dig_r returns to S_IDLE, or restarts S_SETTLE with counter 0 if the new dig_r is one-hot.
  - S_HELD: no further capture until seg_r or dig_r changes. This gives one capture per strobe window. On change, follow the S_SETTLE entry rules.
- Multiple dig_r bits low: no capture, sets sel_err, treated like S_IDLE.
- Re-capture of a digit already in the mask before the frame completes: overwrite the staging value and err bit.
- Frame completion:
  - On the edge where a capture makes the mask all ones, bcd and digit_err load the staging contents (including that capture), frame_valid=1 for exactly the next cycle, and the mask clears.
  - Digits may arrive in any order.
- Latency: from the first pin cycle of a stable pattern to its capture is STABLE+1 edges (1 input register plus STABLE samples).
- Between frames, bcd/digit_err hold their last published values.
- Reset asserted mid-settle or mid-frame: state cleared on that edge; no frame_valid is emitted.

Test Plan:
- NDIG=4, STABLE=3. Drive dig_n=1110/1101/1011/0111 in sequence with seg_n=79, 24, 30, 19, 4 cycles each -> one frame_valid pulse after the 4th capture; bcd=16'h4321, digit_err=0.
- Same sequence but digit 2 held only 2 cycles -> no capture of digit 2, no frame_valid. Repeat digit 2 for 4 cycles -> frame_valid with bcd=16'h4321.
- Digit 1 driven with seg_n=55 (illegal), others 40, and digit 3 driven with 7F -> bcd=16'hF0E0, digit_err=4'b0010.
- dig_n=1100 for 5 cycles mid-scan -> sel_err=1 stays high, no capture. A subsequent clean scan of 10, 00, 78, 02 for digits 0–3 -> bcd=16'h6789.
- rst asserted for 1 cycle after 3 of 4 digits are captured -> no frame_valid. A following full scan of 40 on all digits -> bcd=16'h0000, frame_valid pulses exactly once.
- Digit 0 held stable for 20 cycles -> exactly one capture (S_HELD). Rescanning digit 0 as 12 before the frame completes -> the published frame shows digit 0 = 5.
